addsub_seq_ctrl: RTL and testbench
==================================

# addsub_seq_ctrl

Nibble-serial sequencer that performs WIDTH-bit add or subtract by time-multiplexing one instance of the team's 4-bit add/sub slice, `fourbitaddsub`. It processes one nibble per cycle, least-significant first, and chains the carry between nibbles through a register. It sits between a valid/ready operand source and a valid/ready result sink. It reports the carry-out, signed overflow and zero flags of the full-width operation.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 8. Any other value is an elaboration error.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operand source has a request.
- in_ready  out  1  block can accept a request.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result held and valid.
- out_ready  in  1  sink accepts the result.
- result  out  WIDTH  A+B or A−B, modulo 2^WIDTH.
- cout  out  1  final carry-out. For subtract, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  result == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture a, b and sub into internal registers, clear nib_idx to 0, go to RUN.
- RUN:
  - Drive slice A = a_reg[4k+3:4k] and B = b_reg[4k+3:4k], where k = nib_idx, and Sub = sub_reg.
  - Drive slice Cin = 0 for k=0, and carry_reg ^ sub_reg for k>0. The slice applies its internal Cin^Sub, so the effective carry into nibble k is carry_reg, and is sub_reg for k=0.
  - Each cycle: write slice S into result[4k+3:4k], write slice Cout into carry_reg, increment nib_idx.
  - After nibble NIB−1, where NIB = WIDTH/4, go to DONE.
- DONE:
  - out_valid=1.
  - result, cout and the flags are stable until the handshake.
  - On out_ready: go to IDLE.
- Flag rules:
  - cout = carry_reg after the last nibble.
  - ovf = (a_reg[MSB] ~^ bx[MSB]) & (result[MSB] ^ a_reg[MSB]), where bx = b_reg ^ {WIDTH{sub_reg}}.
  - zero = (result == 0).
  - Flags are meaningful only while out_valid=1.
- Operand inputs are don't-care outside the accept cycle. Changes to a, b or sub after acceptance do not affect the operation in flight.
- in_ready=0 in RUN and DONE. in_valid is ignored there and no request is queued.
- Reset: any state goes to IDLE at the next edge.
  - Reset values: in_ready=1 (after reset is released), out_valid=0, result=0, cout=0, ovf=0, zero=0.
  - Internal registers carry_reg, nib_idx, a_reg, b_reg and sub_reg reset to 0.
  - An operation in progress is discarded with no output.

## Timing
- Cycle 0: accept edge (in_valid&in_ready sampled high).
- Cycles 1..NIB: nibbles 0..NIB−1 computed, one per edge.
- out_valid rises at the edge ending cycle NIB, so latency is NIB+1 edges from accept to out_valid. For WIDTH=16 that is 5 edges.
- out_valid remains 1 with stable outputs for as long as out_ready=0.
- Output handshake edge: out_valid drops to 0 and in_ready rises to 1 at the same edge. A new request is accepted at the following edge or later.
- Minimum period between accepts is NIB+2 cycles when out_ready is held high.
- rst has priority over every handshake in the same cycle.
- in_ready and out_valid are registered-state decodes with no combinational path from in_valid or out_ready.

## Test plan
- Add, WIDTH=16: a=0x1234, b=0x4321, sub=0 -> result=0x5555, cout=0, ovf=0, zero=0, out_valid exactly 5 edges after accept.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1 -> result=0xFFFE, cout=0, ovf=0. Then a=b=0x3C3C, sub=1 -> result=0x0000, cout=1, zero=1.
- Overflow and inter-nibble carry ripple:
  - 0x7FFF+0x0001 -> 0x8000, ovf=1, cout=0.
  - 0x8000−0x0001 -> 0x7FFF, ovf=1, cout=1.
  - 0xFFFF+0x0001 -> 0x0000, cout=1, zero=1.
- Backpressure and isolation:
  - Hold out_ready=0 for 10 cycles. out_valid and result must stay stable and in_ready must stay 0.
  - Toggle a, b, sub and in_valid during RUN. The result must match the captured operands.
- Reset mid-RUN: assert rst at cycle 2 after accept.
  - Next edge: out_valid=0, result=0, in_ready=1.
  - A new request 0x0001+0x0001 then yields 0x0002 with no residue of the aborted operation.
- Random regression, WIDTH=8, 16 and 32: at least 1000 random a/b/sub triples with random out_ready stalls. Results and flags are checked against a behavioural full-width model.

Source files
------------

// File: rtl/addsub_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// addsub_seq_ctrl_if
// Handshake and data bundle for the nibble-serial add/sub sequencer.
//
//   in_valid / in_ready      operand request handshake (source -> block)
//   a, b, sub                operands and operation select (0 = add, 1 = sub)
//   out_valid / out_ready    result handshake (block -> sink)
//   result, cout, ovf, zero  full-width result and flags
//
// master : the operand source / result sink side (e.g. a testbench)
// slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface addsub_seq_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, result, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, result, cout, ovf, zero
   );
endinterface

// File: rtl/addsub_seq_ctrl.sv
// ---------------------------------------------------------------------------
// addsub_seq_ctrl
// WIDTH-bit add/subtract computed one nibble per cycle, least significant
// nibble first, through a single 4-bit add/sub slice (fourbitaddsub). The
// carry between nibbles is held in carry_reg.
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   addsub_seq_ctrl_if.slave
//           in_valid/in_ready, a, b, sub    operand request
//           out_valid/out_ready             result handshake
//           result, cout, ovf, zero         result and flags (valid in DONE)
//
// Latency is WIDTH/4 + 1 edges from the accept edge to out_valid.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// fourbitaddsub
// 4-bit add/sub slice: s = a + (b ^ {4{sub}}) + (cin ^ sub).
// Ports: a, b (4-bit operands), cin, sub in; s (4-bit sum), cout out.
// ---------------------------------------------------------------------------
module fourbitaddsub (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   input  logic       sub,
   output logic [3:0] s,
   output logic       cout
);
   logic [3:0] bx;
   logic [4:0] sum;

   // Invert B and fold the subtract select into the carry so the same adder
   // does both operations.
   always_comb begin
      bx   = b ^ {4{sub}};
      sum  = {1'b0, a} + {1'b0, bx} + {4'b0000, cin ^ sub};
      s    = sum[3:0];
      cout = sum[4];
   end
endmodule

module addsub_seq_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic           clk,
   input  logic           rst,
   addsub_seq_ctrl_if.slave bus
);
   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

   generate
      if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
         $error("addsub_seq_ctrl: WIDTH must be a multiple of 4 and at least 8");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             sub_reg;
   logic             carry_reg;
   logic [IW-1:0]    nib_idx;
   logic [WIDTH-1:0] result_reg;

   logic [3:0]       slice_a;
   logic [3:0]       slice_b;
   logic [3:0]       slice_s;
   logic             slice_cin;
   logic             slice_cout;
   logic             last_nib;
   logic             accept;
   logic [WIDTH-1:0] bx;

   // Handshake decodes come from registered state only, so there is no
   // combinational path from in_valid or out_ready to in_ready/out_valid.
   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign accept        = bus.in_valid && (state == IDLE);
   assign last_nib      = (nib_idx == IW'(NIB - 1));

   // Select the current nibble of each captured operand. The slice applies
   // cin ^ sub internally, so cin is pre-XORed with sub_reg on later nibbles
   // to make the effective carry equal carry_reg; on nibble 0 cin = 0 makes
   // the effective carry equal sub_reg (the +1 of two's-complement negate).
   always_comb begin
      slice_a   = a_reg[{nib_idx, 2'b00} +: 4];
      slice_b   = b_reg[{nib_idx, 2'b00} +: 4];
      slice_cin = (nib_idx == '0) ? 1'b0 : (carry_reg ^ sub_reg);
   end

   fourbitaddsub u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (slice_cin),
      .sub  (sub_reg),
      .s    (slice_s),
      .cout (slice_cout)
   );

   // State register; reset takes priority over any handshake in the cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: accept in IDLE, walk all nibbles in RUN, hold the
   // result in DONE until the sink takes it.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.in_valid) state_next = RUN;
         RUN:     if (last_nib)     state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: capture operands on accept, then write one result nibble and
   // the chained carry per RUN cycle. Nothing changes in DONE, which keeps
   // the outputs stable while the sink stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg      <= '0;
         b_reg      <= '0;
         sub_reg    <= 1'b0;
         carry_reg  <= 1'b0;
         nib_idx    <= '0;
         result_reg <= '0;
      end else begin
         if (accept) begin
            a_reg   <= bus.a;
            b_reg   <= bus.b;
            sub_reg <= bus.sub;
            nib_idx <= '0;
         end else if (state == RUN) begin
            result_reg[{nib_idx, 2'b00} +: 4] <= slice_s;
            carry_reg                         <= slice_cout;
            nib_idx                           <= nib_idx + IW'(1);
         end
      end
   end

   // Flags. Signed overflow occurs when A and the effective B operand share a
   // sign but the result sign differs. ovf and zero are qualified by DONE so
   // they read 0 out of reset and while a partial result is being built.
   assign bx         = b_reg ^ {WIDTH{sub_reg}};
   assign bus.result = result_reg;
   assign bus.cout   = carry_reg;
   assign bus.ovf    = (state == DONE) &&
                       ((a_reg[WIDTH-1] ~^ bx[WIDTH-1]) &&
                        (result_reg[WIDTH-1] ^ a_reg[WIDTH-1]));
   assign bus.zero   = (state == DONE) && (result_reg == '0);
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_addsub_seq_ctrl
// Testbench for addsub_seq_ctrl: a WIDTH=16 instance with a directed vector
// table and hand-written corner sequences, plus WIDTH=8 and WIDTH=32
// instances under random regression against a full-width signed model.
// ---------------------------------------------------------------------------
module tb_addsub_seq_ctrl;
   localparam int W16 = 16;
   localparam int NVEC = 13;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
      logic [15:0] r;
      logic        c;
      logic        v;
      logic        z;
   } vec_t;

   logic clk;
   logic rst;
   logic grst;
   int   tests_run;
   int   tests_failed;
   logic gen_done [2];

   addsub_seq_ctrl_if #(.WIDTH(W16)) bus ();

   addsub_seq_ctrl #(.WIDTH(W16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison goes through here so the counters stay consistent.
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: exact integer arithmetic, overflow from the true signed
   // result leaving the representable range, carry as unsigned carry/no-borrow.
   function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 input int w, output logic [31:0] r, output logic c,
                                 output logic v, output logic z);
      longint mask, ua, ub, sa, sb, tr, hi, lo, ur;
      mask = (64'sd1 <<< w) - 1;
      ua   = longint'({32'd0, a}) & mask;
      ub   = longint'({32'd0, b}) & mask;
      sa   = (ua >= (64'sd1 <<< (w - 1))) ? ua - (64'sd1 <<< w) : ua;
      sb   = (ub >= (64'sd1 <<< (w - 1))) ? ub - (64'sd1 <<< w) : ub;
      hi   = (64'sd1 <<< (w - 1)) - 1;
      lo   = -(64'sd1 <<< (w - 1));
      if (s) begin
         tr = sa - sb;
         c  = (ua >= ub);
         ur = (ua - ub) & mask;
      end else begin
         tr = sa + sb;
         c  = ((ua + ub) >= (64'sd1 <<< w));
         ur = (ua + ub) & mask;
      end
      r = ur[31:0];
      v = (tr > hi) || (tr < lo);
      z = (ur == 0);
   endfunction

   // Launch one operation on the 16-bit DUT and wait for out_valid, checking
   // the accept-to-valid latency. With disturb set, operand inputs and
   // in_valid are scrambled while the operation is in flight.
   task automatic applyStimulus(input vec_t v, input bit disturb, input string tag);
      int edges;
      for (int t = 0; t < 20 && !bus.in_ready; t++) begin
         @(posedge clk); #1;
      end
      check({tag, ".in_ready_before"}, 64'(bus.in_ready), 64'd1);
      bus.a        = v.a;
      bus.b        = v.b;
      bus.sub      = v.sub;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      edges = 0;
      while (!bus.out_valid && edges < 40) begin
         if (disturb) begin
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            bus.sub      = 1'($urandom);
            bus.in_valid = 1'($urandom);
         end
         @(posedge clk); #1;
         edges++;
      end
      bus.in_valid = 1'b0;
      // Accept edge plus one edge per nibble
      check({tag, ".latency"}, 64'(edges + 1), 64'(W16 / 4 + 1));
   endtask

   // Compare the held result, optionally stall the sink for a number of
   // cycles (with in_valid pushed high to show it is not queued), then
   // complete the output handshake.
   task automatic checkOutput(input vec_t v, input int stall, input string tag);
      check({tag, ".result"}, 64'(bus.result), 64'(v.r));
      check({tag, ".cout"},   64'(bus.cout),   64'(v.c));
      check({tag, ".ovf"},    64'(bus.ovf),    64'(v.v));
      check({tag, ".zero"},   64'(bus.zero),   64'(v.z));
      for (int i = 0; i < stall; i++) begin
         bus.in_valid = 1'b1;
         @(posedge clk); #1;
         check({tag, ".stall_valid"},  64'(bus.out_valid), 64'd1);
         check({tag, ".stall_result"}, 64'(bus.result),    64'(v.r));
         check({tag, ".stall_ready"},  64'(bus.in_ready),  64'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({tag, ".post_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, ".post_ready"}, 64'(bus.in_ready),  64'd1);
   endtask

   // Random regression on WIDTH=8 and WIDTH=32 instances, each with its own
   // interface and process, running alongside the 16-bit directed test.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rand
         localparam int W = (gi == 0) ? 8 : 32;
         addsub_seq_ctrl_if #(.WIDTH(W)) gbus ();
         addsub_seq_ctrl #(.WIDTH(W)) gdut (
            .clk (clk),
            .rst (grst),
            .bus (gbus)
         );

         initial begin
            logic [31:0] ra, rb, er;
            logic        rs, ec, ev, ez;
            int          edges;
            gen_done[gi]    = 1'b0;
            gbus.in_valid   = 1'b0;
            gbus.out_ready  = 1'b0;
            gbus.a          = '0;
            gbus.b          = '0;
            gbus.sub        = 1'b0;
            @(negedge grst); #1;
            for (int n = 0; n < 350; n++) begin
               ra = $urandom;
               rb = $urandom;
               rs = 1'($urandom);
               model(ra, rb, rs, W, er, ec, ev, ez);
               for (int t = 0; t < 20 && !gbus.in_ready; t++) begin
                  @(posedge clk); #1;
               end
               gbus.a        = ra[W-1:0];
               gbus.b        = rb[W-1:0];
               gbus.sub      = rs;
               gbus.in_valid = 1'b1;
               @(posedge clk); #1;
               gbus.in_valid = 1'b0;
               edges = 0;
               while (!gbus.out_valid && edges < 4 * W) begin
                  @(posedge clk); #1;
                  edges++;
               end
               check($sformatf("rand%0d.op%0d", W, n),
                     {27'd0, 32'(gbus.result), gbus.cout, gbus.ovf, gbus.zero, gbus.out_valid},
                     {27'd0, er & 32'((64'd1 << W) - 1), ec, ev, ez, 1'b1});
               repeat ($urandom_range(0, 3)) begin
                  @(posedge clk); #1;
               end
               gbus.out_ready = 1'b1;
               @(posedge clk); #1;
               gbus.out_ready = 1'b0;
            end
            gen_done[gi] = 1'b1;
         end
      end
   endgenerate

   // Main directed sequence on the 16-bit instance
   initial begin
      vec_t        vecs [NVEC];
      vec_t        v;
      logic [31:0] er;
      logic        ec, ev, ez;
      int          t;

      vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{16'h3C3C, 16'h3C3C, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[3]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
      vecs[5]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
      vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0, 1'b0};

      tests_run     = 0;
      tests_failed  = 0;
      rst           = 1'b1;
      grst          = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.sub       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.in_ready",  64'(bus.in_ready),  64'd1);
      check("reset.out_valid", 64'(bus.out_valid), 64'd0);
      check("reset.result",    64'(bus.result),    64'd0);
      check("reset.cout",      64'(bus.cout),      64'd0);
      check("reset.ovf",       64'(bus.ovf),       64'd0);
      check("reset.zero",      64'(bus.zero),      64'd0);
      rst  = 1'b0;
      grst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i], 1'b0, $sformatf("vec%0d", i));
         checkOutput(vecs[i], 0, $sformatf("vec%0d", i));
      end

      // Sink backpressure for 10 cycles
      applyStimulus(vecs[0], 1'b0, "stall");
      checkOutput(vecs[0], 10, "stall");

      // Operand and in_valid churn while the operation is in flight
      applyStimulus(vecs[12], 1'b1, "isolate");
      checkOutput(vecs[12], 2, "isolate");
      applyStimulus(vecs[4], 1'b1, "isolate2");
      checkOutput(vecs[4], 0, "isolate2");

      // Reset two cycles after accept discards the operation
      bus.a        = 16'hAAAA;
      bus.b        = 16'h5555;
      bus.sub      = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst.out_valid", 64'(bus.out_valid), 64'd0);
      check("midrst.result",    64'(bus.result),    64'd0);
      check("midrst.in_ready",  64'(bus.in_ready),  64'd1);
      rst = 1'b0;
      v = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
      applyStimulus(v, 1'b0, "postrst");
      checkOutput(v, 0, "postrst");

      // Random regression on the 16-bit instance
      for (int n = 0; n < 400; n++) begin
         v.a   = 16'($urandom);
         v.b   = 16'($urandom);
         v.sub = 1'($urandom);
         model({16'd0, v.a}, {16'd0, v.b}, v.sub, W16, er, ec, ev, ez);
         v.r = er[15:0];
         v.c = ec;
         v.v = ev;
         v.z = ez;
         applyStimulus(v, 1'($urandom_range(0, 3) == 0), $sformatf("rand16.op%0d", n));
         checkOutput(v, $urandom_range(0, 3), $sformatf("rand16.op%0d", n));
      end

      // Let the other-width regressions finish, within a fixed budget
      t = 0;
      while (!(gen_done[0] && gen_done[1]) && t < 40000) begin
         @(posedge clk);
         t++;
      end
      check("rand.completed", 64'(gen_done[0] && gen_done[1]), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
